// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready command to APB initiator bridge
module apb_master_bridge #(
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] apb_paddr_m,
    output logic              apb_pwrite_m,
    output logic              apb_psel_m,
    output logic              apb_penable_m,
    output logic [31:0]       apb_pwdata_m,
    input  logic [31:0]       apb_prdata_m,
    input  logic              apb_pready_m
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // wait_cnt counts ACCESS cycles already ended without pready
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == LAST_WAIT);
    assign cmd_ready_o = rst_ni && (state == ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            apb_paddr_m   <= '0;
            apb_pwrite_m  <= 1'b0;
            apb_pwdata_m  <= '0;
            apb_psel_m    <= 1'b0;
            apb_penable_m <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        apb_paddr_m  <= cmd_addr_i;
                        apb_pwrite_m <= cmd_write_i;
                        apb_pwdata_m <= cmd_wdata_i;
                        apb_psel_m   <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb_penable_m <= 1'b1;
                    state         <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb_pready_m) begin
                        apb_psel_m    <= 1'b0;
                        apb_penable_m <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= apb_pwrite_m ? 32'd0 : apb_prdata_m;
                        rsp_err_o     <= 1'b0;
                        state         <= ST_RESP;
                    end else if (timeout_hit) begin
                        apb_psel_m    <= 1'b0;
                        apb_penable_m <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= 32'd0;
                        rsp_err_o     <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int ADDR_W = 5;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite, psel, penable, pready;
    logic [31:0]       pwdata, prdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .apb_paddr_m(paddr), .apb_pwrite_m(pwrite), .apb_psel_m(psel),
        .apb_penable_m(penable), .apb_pwdata_m(pwdata),
        .apb_prdata_m(prdata), .apb_pready_m(pready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer: the slave asserts pready in ACCESS cycle waits+1; bp = cycles of rsp backpressure
    task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdat, input logic early_ready,
                           input int bp);
        int cyc, n_setup, n_acc, exp_acc, rsp_cyc;
        logic exp_err;
        logic [31:0] exp_rdata;
        exp_err   = (waits >= TMO);
        exp_acc   = exp_err ? TMO : waits + 1;
        exp_rdata = (exp_err || wr) ? 32'd0 : rdat;

        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_psel", 32'(psel), 32'd0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ADDR_W'($urandom); cmd_wdata = $urandom;

        cyc = 0; n_setup = 0; n_acc = 0; rsp_cyc = 0;
        while (rsp_cyc == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            pready = 1'b0;
            prdata = $urandom;
            if (rsp_valid) begin
                rsp_cyc = cyc;
            end else if (psel && !penable) begin
                n_setup++;
                if (early_ready) begin pready = 1'b1; prdata = rdat; end
            end else if (psel && penable) begin
                n_acc++;
                check("acc_paddr", 32'(paddr), 32'(addr));
                check("acc_pwrite", 32'(pwrite), 32'(wr));
                check("acc_pwdata", pwdata, wdata);
                check("acc_cmd_ready", 32'(cmd_ready), 32'd0);
                if (n_acc - 1 == waits) begin pready = 1'b1; prdata = rdat; end
            end
        end
        pready = 1'b0;
        check("setup_cycles", 32'(n_setup), 32'd1);
        check("access_cycles", 32'(n_acc), 32'(exp_acc));
        check("rsp_cycle", 32'(rsp_cyc), 32'(2 + exp_acc));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("resp_psel", 32'(psel), 32'd0);
        check("resp_cmd_ready", 32'(cmd_ready), 32'd0);

        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, exp_rdata);
            check("bp_rsp_err", 32'(rsp_err), 32'(exp_err));
            check("bp_psel", 32'(psel), 32'd0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int wait_tbl[9];
        int n_acc;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
        wait_tbl = '{0, 1, 2, 3, 4, 14, 15, 16, 25};

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        run_txn(1'b1, 5'h04, 32'h0000_1234, 0, 32'hFFFF_FFFF, 1'b0, 0);
        run_txn(1'b0, 5'h00, 32'h0, 0, 32'hDEAD_BEEF, 1'b1, 0);
        run_txn(1'b0, 5'h08, 32'h0, 3, 32'hCAFE_0003, 1'b0, 0);
        run_txn(1'b0, 5'h0C, 32'h0, 16, 32'h1111_1111, 1'b0, 0);
        run_txn(1'b0, 5'h0C, 32'h0, 15, 32'h2222_2222, 1'b0, 0);
        run_txn(1'b1, 5'h10, 32'hA5A5_5A5A, 2, 32'h3333_3333, 1'b1, 5);

        for (int t = 0; t < 14; t++) begin
            run_txn(1'($urandom), ADDR_W'($urandom), $urandom,
                    wait_tbl[$urandom_range(0, 8)], $urandom, 1'($urandom),
                    int'($urandom_range(0, 3)));
        end

        // reset pulse during ACCESS drops everything and produces no response
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h14;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 20 && n_acc < 3; i++) begin
            @(negedge clk);
            if (psel && penable) n_acc++;
        end
        check("rst_mid_reached_access", 32'(n_acc), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("amid_psel", 32'(psel), 32'd0);
        check("amid_penable", 32'(penable), 32'd0);
        check("amid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("amid_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("after_rst_psel", 32'(psel), 32'd0);
        end
        run_txn(1'b0, 5'h14, 32'h0, 1, 32'h5EED_1234, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
